// File: rtl/ss2_cobs_decoder.sv
// Streaming COBS decoder feeding the SimpleSerial v2 parser.
// Decoded bytes pass through a one-byte stage so the final byte can carry out_last.
module ss2_cobs_decoder #(
    parameter int pMAX_LEN = 255,
    parameter int pTIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    output logic       frame_error,
    output logic       busy
);

    localparam int LEN_W = $clog2(pMAX_LEN + 1);
    localparam int TMO_W = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CODE,
        DISCARD
    } state_t;

    state_t            state, state_n;
    logic [7:0]        rem, rem_n;
    logic              zpend, zpend_n;
    logic [7:0]        stage_data, stage_data_n;
    logic              stage_full, stage_full_n;
    logic [LEN_W-1:0]  length, length_n;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_n;
    logic [7:0]        out_data_n;
    logic              out_valid_n, out_last_n, frame_error_n;
    logic              push_req;
    logic [7:0]        push_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rem         <= 8'h00;
            zpend       <= 1'b0;
            stage_data  <= 8'h00;
            stage_full  <= 1'b0;
            length      <= '0;
            tmo_cnt     <= '0;
            out_data    <= 8'h00;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            rem         <= rem_n;
            zpend       <= zpend_n;
            stage_data  <= stage_data_n;
            stage_full  <= stage_full_n;
            length      <= length_n;
            tmo_cnt     <= tmo_cnt_n;
            out_data    <= out_data_n;
            out_valid   <= out_valid_n;
            out_last    <= out_last_n;
            frame_error <= frame_error_n;
            busy        <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n       = state;
        rem_n         = rem;
        zpend_n       = zpend;
        stage_data_n  = stage_data;
        stage_full_n  = stage_full;
        length_n      = length;
        tmo_cnt_n     = tmo_cnt;
        out_data_n    = out_data;
        out_valid_n   = 1'b0;
        out_last_n    = 1'b0;
        frame_error_n = 1'b0;
        push_req      = 1'b0;
        push_byte     = 8'h00;

        if (in_valid) begin
            tmo_cnt_n = '0;
            case (state)
                IDLE: begin
                    if (in_data != 8'h00) begin
                        rem_n   = in_data - 8'd1;
                        zpend_n = (in_data != 8'hFF);
                        state_n = (in_data == 8'h01) ? CODE : DATA;
                    end
                end
                DATA: begin
                    if (in_data == 8'h00) begin
                        frame_error_n = 1'b1;
                        stage_full_n  = 1'b0;
                        state_n       = IDLE;
                    end else begin
                        push_req  = 1'b1;
                        push_byte = in_data;
                        rem_n     = rem - 8'd1;
                        if (rem == 8'd1) begin
                            state_n = CODE;
                        end
                    end
                end
                CODE: begin
                    if (in_data == 8'h00) begin
                        // A trailing pending zero is the COBS terminator, never data.
                        if (stage_full) begin
                            out_valid_n = 1'b1;
                            out_last_n  = 1'b1;
                            out_data_n  = stage_data;
                        end
                        stage_full_n = 1'b0;
                        state_n      = IDLE;
                    end else begin
                        push_req  = zpend;
                        push_byte = 8'h00;
                        rem_n     = in_data - 8'd1;
                        zpend_n   = (in_data != 8'hFF);
                        state_n   = (in_data == 8'h01) ? CODE : DATA;
                    end
                end
                DISCARD: begin
                    if (in_data == 8'h00) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE && pTIMEOUT != 0) begin
            if (tmo_cnt == TMO_W'(pTIMEOUT - 1)) begin
                tmo_cnt_n     = '0;
                state_n       = IDLE;
                stage_full_n  = 1'b0;
                frame_error_n = (state != DISCARD);
            end else begin
                tmo_cnt_n = tmo_cnt + TMO_W'(1);
            end
        end else begin
            tmo_cnt_n = '0;
        end

        // Overflow wins over any code load above and drops the staged byte.
        if (push_req) begin
            if (length >= LEN_W'(pMAX_LEN)) begin
                frame_error_n = 1'b1;
                stage_full_n  = 1'b0;
                out_valid_n   = 1'b0;
                state_n       = DISCARD;
            end else begin
                if (stage_full) begin
                    out_valid_n = 1'b1;
                    out_data_n  = stage_data;
                end
                stage_data_n = push_byte;
                stage_full_n = 1'b1;
                length_n     = length + LEN_W'(1);
            end
        end

        if (state_n == IDLE) begin
            length_n = '0;
        end
    end

endmodule

// File: tb/tb_ss2_cobs_decoder.sv
// Bench for ss2_cobs_decoder: directed frames plus random payloads COBS-encoded here
// and compared against the original payload after decoding.
module tb_ss2_cobs_decoder;

    localparam int MAX_LEN = 255;
    localparam int TIMEOUT = 50;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       frame_error;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int err_seen = 0;

    logic [8:0] obs[$];
    logic [8:0] expq[$];
    logic [7:0] txq[$];
    logic [7:0] pay[$];

    ss2_cobs_decoder #(.pMAX_LEN(MAX_LEN), .pTIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_last(out_last),
        .frame_error(frame_error),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock step; outputs are sampled 1ns after the edge and logged for frame checks.
    task automatic applyStimulus(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        checkOutput("valid_without_input", 32'(out_valid & ~v), 32'd0);
        checkOutput("valid_with_error", 32'(out_valid & frame_error), 32'd0);
        if (out_valid) obs.push_back({out_last, out_data});
        if (frame_error) err_seen++;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic sendTx(input int max_gap);
        for (int i = 0; i < txq.size(); i++) begin
            applyStimulus(1'b1, txq[i]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic checkFrame(input string tag, input int exp_err);
        int n;
        checkOutput({tag, "_count"}, 32'(obs.size()), 32'(expq.size()));
        n = (obs.size() < expq.size()) ? obs.size() : expq.size();
        for (int i = 0; i < n; i++)
            checkOutput({tag, "_byte"}, 32'(obs[i]), 32'(expq[i]));
        checkOutput({tag, "_errors"}, 32'(err_seen), 32'(exp_err));
        obs.delete();
        expq.delete();
        err_seen = 0;
    endtask

    // Reference COBS encoder: payload in pay -> encoded bytes plus delimiter in txq.
    task automatic cobsEncode();
        int code_idx;
        logic [7:0] code;
        txq.delete();
        code_idx = 0;
        txq.push_back(8'h00);
        code = 8'd1;
        foreach (pay[i]) begin
            if (pay[i] == 8'h00) begin
                txq[code_idx] = code;
                code_idx = txq.size();
                txq.push_back(8'h00);
                code = 8'd1;
            end else begin
                txq.push_back(pay[i]);
                code++;
                if (code == 8'hFF) begin
                    txq[code_idx] = code;
                    code_idx = txq.size();
                    txq.push_back(8'h00);
                    code = 8'd1;
                end
            end
        end
        txq[code_idx] = code;
        txq.push_back(8'h00);
    endtask

    task automatic expectPayload();
        expq.delete();
        foreach (pay[i]) expq.push_back({(i == pay.size() - 1) ? 1'b1 : 1'b0, pay[i]});
    endtask

    task automatic randomPayload(input int len, input bit allow_zero);
        pay.delete();
        for (int i = 0; i < len; i++) begin
            if (allow_zero && $urandom_range(0, 3) == 0) pay.push_back(8'h00);
            else pay.push_back(8'($urandom_range(1, 255)));
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_last", 32'(out_last), 32'd0);
        checkOutput("reset_frame_error", 32'(frame_error), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        txq = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
        sendTx(0);
        checkOutput("t1_last_data", 32'(out_data), 32'h33);
        checkOutput("t1_last_flag", 32'(out_last), 32'd1);
        checkOutput("t1_busy", 32'(busy), 32'd0);
        expq = '{9'h011, 9'h022, 9'h000, 9'h133};
        checkFrame("t1", 0);

        txq = '{8'h01, 8'h01, 8'h00};
        sendTx(2);
        expq = '{9'h100};
        checkFrame("t2a", 0);
        txq = '{8'h01, 8'h00};
        sendTx(0);
        checkFrame("t2b", 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h00);
            checkOutput("t2c_busy", 32'(busy), 32'd0);
        end
        checkFrame("t2c", 0);

        txq = '{8'h04, 8'hAA, 8'hBB, 8'h00};
        sendTx(0);
        checkOutput("t3_error_pulse", 32'(frame_error), 32'd1);
        checkOutput("t3_busy", 32'(busy), 32'd0);
        expq = '{9'h0AA};
        checkFrame("t3", 1);
        txq = '{8'h02, 8'h55, 8'h00};
        sendTx(0);
        expq = '{9'h155};
        checkFrame("t3_resync", 0);

        // Longest legal frame, then one byte over the limit.
        randomPayload(MAX_LEN, 1'b1);
        cobsEncode();
        sendTx(3);
        expectPayload();
        checkFrame("max_len", 0);
        randomPayload(MAX_LEN + 1 + $urandom_range(0, 20), 1'b1);
        cobsEncode();
        sendTx(2);
        for (int i = 0; i < MAX_LEN - 1; i++) expq.push_back({1'b0, pay[i]});
        checkFrame("overflow", 1);

        // Overflow with no delimiter: DISCARD must time out silently.
        randomPayload(MAX_LEN + 5, 1'b0);
        cobsEncode();
        void'(txq.pop_back());
        sendTx(0);
        idle(TIMEOUT + 10);
        checkOutput("discard_tmo_busy", 32'(busy), 32'd0);
        for (int i = 0; i < MAX_LEN - 1; i++) expq.push_back({1'b0, pay[i]});
        checkFrame("discard_tmo", 1);
        txq = '{8'h02, 8'h66, 8'h00};
        sendTx(0);
        expq = '{9'h166};
        checkFrame("after_discard", 0);

        txq = '{8'h03, 8'hAA};
        sendTx(0);
        idle(TIMEOUT - 1);
        checkOutput("tmo_early", 32'(err_seen), 32'd0);
        checkOutput("tmo_busy_before", 32'(busy), 32'd1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("tmo_error_pulse", 32'(frame_error), 32'd1);
        checkOutput("tmo_busy_after", 32'(busy), 32'd0);
        checkFrame("tmo", 1);
        txq = '{8'h02, 8'h77, 8'h00};
        sendTx(0);
        expq = '{9'h177};
        checkFrame("tmo_resync", 0);
        txq = '{8'h03, 8'hAA};
        sendTx(0);
        idle(TIMEOUT - 1);
        txq = '{8'hBB, 8'h00};
        sendTx(0);
        expq = '{9'h0AA, 9'h1BB};
        checkFrame("tmo_49", 0);

        txq = '{8'h04, 8'h10, 8'h20};
        sendTx(0);
        expq = '{9'h010};
        checkFrame("pre_reset", 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_out_data", 32'(out_data), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        txq = '{8'h02, 8'h99, 8'h00};
        sendTx(0);
        expq = '{9'h199};
        checkFrame("post_reset", 0);

        randomPayload(254, 1'b0);
        txq.delete();
        txq.push_back(8'hFF);
        foreach (pay[i]) txq.push_back(pay[i]);
        txq.push_back(8'h00);
        sendTx(0);
        expectPayload();
        checkFrame("ff_block", 0);

        for (int f = 0; f < 25; f++) begin
            randomPayload((f == 7) ? 254 : $urandom_range(0, 40), f != 7);
            cobsEncode();
            sendTx(5);
            expectPayload();
            checkFrame("random", 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
